multiway_tag_bank: RTL and testbench

MULTIWAY_TAG_BANK -- requirements
Module: multiway_tag_bank

---
 rtl/multiway_tag_bank.sv | 133 +++++++++++++
 tb/tb_multiway_tag_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multiway_tag_bank.sv
// Set-associative tag/valid store: WAYS independent columns of LINES entries,
// 1-cycle lookup with same-cycle write forwarding, and a line-by-line flush engine.
module multiway_tag_bank #(
    parameter int WAYS      = 2,
    parameter int LINES     = 512,
    parameter int TAG_WIDTH = 20,
    localparam int LW       = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    output logic                 lookup_ready,
    input  logic [LW-1:0]        lookup_line,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    output logic                 hit_valid,
    output logic [WAYS-1:0]      hit_way,
    output logic                 hit,
    input  logic                 update_en,
    input  logic [LW-1:0]        update_line,
    input  logic [WAYS-1:0]      update_way,
    input  logic [TAG_WIDTH-1:0] update_tag,
    input  logic                 flush_req,
    output logic                 flush_busy
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    state_t              state_reg, state_next;
    logic [LW-1:0]       counter_reg, counter_next;
    logic                hit_valid_reg;
    logic [TAG_WIDTH-1:0] lookup_tag_reg;
    logic [TAG_WIDTH-1:0] fwd_tag_reg;
    logic                lookup_fire;
    logic                update_fire;

    assign flush_busy   = (state_reg == FLUSH);
    assign lookup_ready = !flush_busy;
    assign lookup_fire  = lookup_valid && lookup_ready;
    assign update_fire  = update_en && !flush_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FLUSH;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next   = FLUSH;
                    counter_next = '0;
                end
            end
            FLUSH: begin
                counter_next = counter_reg + 1'b1;
                if (counter_reg == LAST_LINE) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end
            end
            default: state_next = FLUSH;
        endcase
    end

    // Only the result-valid flag needs reset; captured lookup data is don't-care while it is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_valid_reg <= 1'b0;
        end else begin
            hit_valid_reg <= lookup_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (lookup_fire) begin
            lookup_tag_reg <= lookup_tag;
            fwd_tag_reg    <= update_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_WIDTH-1:0] tag_mem [LINES];
            logic                 valid_mem [LINES];
            logic [TAG_WIDTH-1:0] tag_rd_reg;
            logic                 valid_rd_reg;
            logic                 fwd_reg;
            logic                 way_write;

            assign way_write = update_fire && update_way[gi];

            always_ff @(posedge clk) begin
                if (way_write) begin
                    tag_mem[update_line] <= update_tag;
                end
                if (lookup_fire) begin
                    tag_rd_reg <= tag_mem[lookup_line];
                end
            end

            // Flush and update never coincide, so one write port covers both.
            always_ff @(posedge clk) begin
                if (flush_busy) begin
                    valid_mem[counter_reg] <= 1'b0;
                end else if (way_write) begin
                    valid_mem[update_line] <= 1'b1;
                end
                if (lookup_fire) begin
                    valid_rd_reg <= valid_mem[lookup_line];
                    fwd_reg      <= way_write && (update_line == lookup_line);
                end
            end

            assign hit_way[gi] = hit_valid_reg &&
                (fwd_reg ? (fwd_tag_reg == lookup_tag_reg)
                         : (valid_rd_reg && (tag_rd_reg == lookup_tag_reg)));
        end
    endgenerate

    assign hit_valid = hit_valid_reg;
    assign hit       = |hit_way;

endmodule

// File: tb/tb_multiway_tag_bank.sv
// Drives an 8-line and a 6-line bank from shared stimulus and compares both
// against an array-based model of the tag/valid contents and flush timing.
module tb_multiway_tag_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [2:0] lookup_line = '0;
    logic [3:0] lookup_tag = '0;
    logic       update_en = 1'b0;
    logic [2:0] update_line = '0;
    logic [1:0] update_way = '0;
    logic [3:0] update_tag = '0;
    logic       flush_req = 1'b0;
    logic [2:0] b_lookup_line, b_update_line;

    logic [1:0] busy_o, ready_o, hv_o, hit_o;
    logic [1:0] hw_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign b_lookup_line = lookup_line % 3'd6;
    assign b_update_line = update_line % 3'd6;

    multiway_tag_bank #(.WAYS(2), .LINES(8), .TAG_WIDTH(4)) u_a (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_ready(ready_o[0]),
        .lookup_line(lookup_line), .lookup_tag(lookup_tag),
        .hit_valid(hv_o[0]), .hit_way(hw_o[0]), .hit(hit_o[0]),
        .update_en(update_en), .update_line(update_line),
        .update_way(update_way), .update_tag(update_tag),
        .flush_req(flush_req), .flush_busy(busy_o[0])
    );

    multiway_tag_bank #(.WAYS(2), .LINES(6), .TAG_WIDTH(4)) u_b (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_ready(ready_o[1]),
        .lookup_line(b_lookup_line), .lookup_tag(lookup_tag),
        .hit_valid(hv_o[1]), .hit_way(hw_o[1]), .hit(hit_o[1]),
        .update_en(update_en), .update_line(b_update_line),
        .update_way(update_way), .update_tag(update_tag),
        .flush_req(flush_req), .flush_busy(busy_o[1])
    );

    // Reference model: contents per instance/way/line plus remaining flush cycles.
    bit         mv [2][2][8];
    logic [3:0] mt [2][2][8];
    int         busy_left [2];
    int         nl [2] = '{8, 6};
    bit         exp_hv [2];
    logic [1:0] exp_hw [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int k);
        for (int w = 0; w < 2; w++)
            for (int l = 0; l < 8; l++)
                mv[k][w][l] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit ready;
            int ll, ul;
            ready = (busy_left[k] == 0);
            ll = (k == 0) ? int'(lookup_line) : int'(lookup_line) % 6;
            ul = (k == 0) ? int'(update_line) : int'(update_line) % 6;
            if (ready && update_en)
                for (int w = 0; w < 2; w++)
                    if (update_way[w]) begin
                        mv[k][w][ul] = 1'b1;
                        mt[k][w][ul] = update_tag;
                    end
            exp_hv[k] = ready && lookup_valid;
            exp_hw[k] = '0;
            if (exp_hv[k])
                for (int w = 0; w < 2; w++)
                    exp_hw[k][w] = mv[k][w][ll] && (mt[k][w][ll] == lookup_tag);
            if (ready && flush_req) begin
                model_clear(k);
                busy_left[k] = nl[k];
            end else if (!ready) begin
                busy_left[k]--;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(busy_left[k] != 0));
            check_eq($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(busy_left[k] == 0));
            check_eq($sformatf("hit_valid%0d", k), 32'(hv_o[k]), 32'(exp_hv[k]));
            check_eq($sformatf("hit_way%0d", k), 32'(hw_o[k]), 32'(exp_hw[k]));
            check_eq($sformatf("hit%0d", k), 32'(hit_o[k]), 32'(|exp_hw[k]));
        end
        check_eq("b_counter_max", 32'(u_b.counter_reg <= 3'd5), 32'd1);
        if (exp_hv[0])
            $display("lookup a: hit_way=%b hit=%0b (exp %b)", hw_o[0], hit_o[0], exp_hw[0]);
    endtask

    // Asserts rst between edges and checks the outputs respond without waiting for a clock.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_busy%0d", k), 32'(busy_o[k]), 32'd1);
            check_eq($sformatf("rst_ready%0d", k), 32'(ready_o[k]), 32'd0);
            check_eq($sformatf("rst_hv%0d", k), 32'(hv_o[k]), 32'd0);
            check_eq($sformatf("rst_hw%0d", k), 32'(hw_o[k]), 32'd0);
            check_eq($sformatf("rst_hit%0d", k), 32'(hit_o[k]), 32'd0);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            busy_left[k] = nl[k];
        end
    endtask

    task automatic idle_in();
        lookup_valid = 1'b0;
        update_en    = 1'b0;
        flush_req    = 1'b0;
    endtask

    task automatic set_lookup(input logic [2:0] line, input logic [3:0] tag);
        lookup_valid = 1'b1;
        lookup_line  = line;
        lookup_tag   = tag;
    endtask

    task automatic set_update(input logic [2:0] line, input logic [1:0] way, input logic [3:0] tag);
        update_en   = 1'b1;
        update_line = line;
        update_way  = way;
        update_tag  = tag;
    endtask

    initial begin
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) step();

        // lookup into a freshly flushed bank
        set_lookup(3'd3, 4'h5); step(); idle_in();

        set_update(3'd3, 2'b10, 4'h5); step(); idle_in();
        set_lookup(3'd3, 4'h5); step();
        set_lookup(3'd3, 4'h6); step(); idle_in();

        // write-before-read forwarding
        set_update(3'd4, 2'b01, 4'hA); set_lookup(3'd4, 4'hA); step(); idle_in();

        set_update(3'd2, 2'b11, 4'h7); step(); idle_in();
        set_lookup(3'd2, 4'h7); step(); idle_in();
        flush_req = 1'b1; step(); flush_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_update(3'd2, 2'b11, 4'h7);
            flush_req = (i == 3);
            step();
        end
        idle_in();
        set_lookup(3'd2, 4'h7); step(); idle_in();

        // reset in the middle of a flush restarts it from scratch
        flush_req = 1'b1; step(); flush_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        do_reset();
        for (int i = 0; i < 8; i++) step();

        // fill every line of both banks, flush, then confirm all lines read invalid
        for (int l = 0; l < 8; l++) begin
            set_update(3'(l), 2'b11, 4'(l + 1)); step();
        end
        idle_in();
        flush_req = 1'b1; step(); flush_req = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int l = 0; l < 8; l++) begin
            set_lookup(3'(l), 4'(l + 1)); step();
        end
        idle_in();

        for (int i = 0; i < 600; i++) begin
            lookup_valid = 1'($urandom_range(0, 1));
            lookup_line  = 3'($urandom_range(0, 7));
            lookup_tag   = 4'($urandom_range(0, 3));
            update_en    = 1'($urandom_range(0, 1));
            update_line  = ($urandom_range(0, 3) == 0) ? lookup_line : 3'($urandom_range(0, 7));
            update_way   = 2'($urandom_range(0, 3));
            update_tag   = 4'($urandom_range(0, 3));
            flush_req    = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
